// File: rtl/fl_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fl_ctrl
// Brief    : Free-list controller for an R10000-style rename stage. Mirrors
//            the free-list head/tail pointers, stalls dispatch when no entry
//            is free or no checkpoint is left, and keeps a circular stack of
//            per-branch head checkpoints that a mispredict restores in one
//            rollback cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fl_ctrl #(
    parameter int NUM_FL = 32,
    parameter int NUM_BR = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        disp_req,
    input  logic                        disp_dest,
    input  logic                        disp_br,
    output logic                        disp_ack,
    output logic [$clog2(NUM_BR)-1:0]   disp_br_tag,
    input  logic                        ret_req,
    input  logic                        br_resolve,
    input  logic                        br_mispredict,
    input  logic [$clog2(NUM_BR)-1:0]   br_tag,
    output logic                        dispatch_en,
    output logic                        retire_en,
    output logic                        rollback_en,
    output logic [$clog2(NUM_FL)-1:0]   FL_rollback_idx,
    output logic [$clog2(NUM_FL):0]     free_cnt,
    output logic                        br_full
);

    localparam int c_fl_aw  = $clog2(NUM_FL);
    localparam int c_ptr_w  = c_fl_aw + 1;
    localparam int c_br_w   = $clog2(NUM_BR);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_ROLLBACK = 1'b1
    } state_t;

    state_t                 r_state;
    logic [c_ptr_w-1:0]     r_head_x;
    logic [c_ptr_w-1:0]     r_tail_x;
    logic [c_ptr_w-1:0]     r_free_cnt;
    logic [c_ptr_w-1:0]     r_rb_idx;
    logic [c_ptr_w-1:0]     r_ck_head_x [NUM_BR];
    logic [NUM_BR-1:0]      r_ck_valid;
    logic [c_br_w-1:0]      r_ck_old;
    logic [c_br_w-1:0]      r_ck_new;

    logic                   w_mis_valid;
    logic                   w_res_valid;
    logic                   w_push;
    logic [c_br_w-1:0]      w_dist;
    logic [c_br_w:0]        w_span;
    logic [NUM_BR-1:0]      w_kill;
    logic [c_ptr_w-1:0]     w_head_nxt;
    logic [c_ptr_w-1:0]     w_tail_nxt;
    logic [c_ptr_w-1:0]     w_ck_val;

    // Handshake and free-list strobes, all combinational in the current cycle
    always_comb begin
        br_full     = r_ck_valid[r_ck_new];
        w_mis_valid = br_mispredict & r_ck_valid[br_tag];
        w_res_valid = br_resolve & r_ck_valid[br_tag];
        disp_ack    = disp_req & (r_state == ST_IDLE) & ~br_mispredict
                    & ~(disp_dest & (r_free_cnt == '0))
                    & ~(disp_br & br_full);
        dispatch_en = disp_ack & disp_dest;
        retire_en   = ret_req;
        w_push      = disp_ack & disp_br;
        disp_br_tag = r_ck_new;
        w_ck_val    = r_head_x + {{(c_ptr_w-1){1'b0}}, disp_dest};
    end

    // Entries from the mispredicted tag up to the youngest are squashed; a
    // zero distance can only mean a full stack, so it spans every entry
    always_comb begin
        w_dist = r_ck_new - br_tag;
        w_span = (w_dist == '0) ? (c_br_w+1)'(NUM_BR) : {1'b0, w_dist};
        w_kill = '0;
        for (int i = 0; i < NUM_BR; i++) begin
            w_kill[i] = w_mis_valid && ({1'b0, c_br_w'(i) - br_tag} < w_span);
        end
    end

    // Next pointer values; retire always applies, rollback overrides dispatch
    always_comb begin
        w_tail_nxt = r_tail_x + {{(c_ptr_w-1){1'b0}}, retire_en};
        if (r_state == ST_ROLLBACK) begin
            w_head_nxt = r_rb_idx;
        end else if (dispatch_en) begin
            w_head_nxt = r_head_x + {{(c_ptr_w-1){1'b0}}, 1'b1};
        end else begin
            w_head_nxt = r_head_x;
        end
    end

    // Pointer mirror and registered free count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head_x   <= '0;
            r_tail_x   <= c_ptr_w'(NUM_FL);
            r_free_cnt <= c_ptr_w'(NUM_FL);
        end else begin
            r_head_x   <= w_head_nxt;
            r_tail_x   <= w_tail_nxt;
            r_free_cnt <= w_tail_nxt - w_head_nxt;
        end
    end

    // Checkpoint stack: allocate at ck_new, clear on resolve/squash, and let
    // ck_old walk over cleared entries at the oldest end
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ck_valid <= '0;
            r_ck_old   <= '0;
            r_ck_new   <= '0;
            for (int i = 0; i < NUM_BR; i++) begin
                r_ck_head_x[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BR; i++) begin
                if (w_kill[i]) begin
                    r_ck_valid[i] <= 1'b0;
                end else if (w_res_valid && (br_tag == c_br_w'(i))) begin
                    r_ck_valid[i] <= 1'b0;
                end else if (w_push && (r_ck_new == c_br_w'(i))) begin
                    r_ck_valid[i]  <= 1'b1;
                    r_ck_head_x[i] <= w_ck_val;
                end
            end
            if (w_mis_valid) begin
                r_ck_new <= br_tag;
            end else if (w_push) begin
                r_ck_new <= r_ck_new + 1'b1;
            end
            if (!r_ck_valid[r_ck_old] && ((r_ck_old != r_ck_new) || (|r_ck_valid))) begin
                r_ck_old <= r_ck_old + 1'b1;
            end
        end
    end

    // Rollback sequencer: one ROLLBACK cycle per valid mispredict
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rb_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mis_valid) begin
                        r_rb_idx <= r_ck_head_x[br_tag];
                        r_state  <= ST_ROLLBACK;
                    end
                end
                ST_ROLLBACK: begin
                    if (w_mis_valid) begin
                        r_rb_idx <= r_ck_head_x[br_tag];
                        r_state  <= ST_ROLLBACK;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rollback_en     = (r_state == ST_ROLLBACK);
    assign FL_rollback_idx = r_rb_idx[c_fl_aw-1:0];
    assign free_cnt        = r_free_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fl_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fl_ctrl
// Brief    : Self-checking bench for fl_ctrl: directed scenarios followed by
//            randomized traffic, checked against an age-ordered branch queue
//            and unbounded pointer counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fl_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       disp_req, disp_dest, disp_br;
    logic       disp_ack;
    logic [1:0] disp_br_tag;
    logic       ret_req, br_resolve, br_mispredict;
    logic [1:0] br_tag;
    logic       dispatch_en, retire_en, rollback_en;
    logic [4:0] FL_rollback_idx;
    logic [5:0] free_cnt;
    logic       br_full;

    fl_ctrl #(.NUM_FL(32), .NUM_BR(4)) u_dut (
        .clock           (clock),
        .reset           (reset),
        .disp_req        (disp_req),
        .disp_dest       (disp_dest),
        .disp_br         (disp_br),
        .disp_ack        (disp_ack),
        .disp_br_tag     (disp_br_tag),
        .ret_req         (ret_req),
        .br_resolve      (br_resolve),
        .br_mispredict   (br_mispredict),
        .br_tag          (br_tag),
        .dispatch_en     (dispatch_en),
        .retire_en       (retire_en),
        .rollback_en     (rollback_en),
        .FL_rollback_idx (FL_rollback_idx),
        .free_cnt        (free_cnt),
        .br_full         (br_full)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: unbounded pointer counters and outstanding branches
    // kept in program order (oldest first)
    typedef struct { int tag; int ck; } br_t;
    br_t q[$];
    int  m_head, m_tail, m_rb, m_ck_new;
    bit  m_rbst;

    // Last sampled DUT outputs, for directed checks against constants
    int  s_ack, s_tag, s_full, s_rb_en, s_rb_idx, s_free;

    function automatic int q_find(input int t);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == t) return i;
        end
        return -1;
    endfunction

    function automatic void m_reset();
        m_head = 0; m_tail = 32; m_rb = 0; m_ck_new = 0; m_rbst = 0;
        q.delete();
    endfunction

    task automatic idle_in();
        reset = 0; disp_req = 0; disp_dest = 0; disp_br = 0;
        ret_req = 0; br_resolve = 0; br_mispredict = 0; br_tag = 0;
    endtask

    // One clock: compare current outputs at the falling edge, advance the model
    task automatic step();
        int  e_ack, mi, ri;
        bit  e_full;
        @(negedge clock);
        s_ack = disp_ack; s_tag = disp_br_tag; s_full = br_full;
        s_rb_en = rollback_en; s_rb_idx = FL_rollback_idx; s_free = free_cnt;
        e_full = (q_find(m_ck_new) >= 0);
        e_ack  = disp_req && !m_rbst && !br_mispredict
              && !(disp_dest && (m_tail - m_head) == 0) && !(disp_br && e_full);
        check("disp_ack", s_ack, e_ack);
        check("dispatch_en", dispatch_en, e_ack & disp_dest);
        check("retire_en", retire_en, ret_req);
        check("br_full", s_full, e_full);
        check("free_cnt", s_free, m_tail - m_head);
        check("rollback_en", s_rb_en, m_rbst);
        if (m_rbst) check("rb_idx", s_rb_idx, m_rb % 32);
        if (e_ack && disp_br) check("br_tag", s_tag, m_ck_new);
        if (reset) begin
            m_reset();
        end else begin
            mi = br_mispredict ? q_find(br_tag) : -1;
            ri = br_resolve ? q_find(br_tag) : -1;
            if (e_ack && disp_br) begin
                q.push_back('{m_ck_new, m_head + int'(disp_dest)});
                m_ck_new = (m_ck_new + 1) % 4;
            end
            if (e_ack && disp_dest) m_head++;
            if (m_rbst) m_head = m_rb;
            if (ret_req) m_tail++;
            if (mi >= 0) begin
                m_rb = q[mi].ck;
                while (q.size() > mi) void'(q.pop_back());
                m_ck_new = br_tag;
                m_rbst = 1;
            end else begin
                m_rbst = 0;
                if (ri >= 0) q.delete(ri);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_in(); reset = 1; step(); reset = 0;
    endtask

    // Lowest pointer any future rollback could restore; bounds legal retires
    function automatic int low_ptr();
        int lo = m_head;
        if (m_rbst && m_rb < lo) lo = m_rb;
        if (q.size() > 0 && q[0].ck < lo) lo = q[0].ck;
        return lo;
    endfunction

    initial begin
        idle_in();
        reset = 1;
        @(posedge clock); #1;
        m_reset();
        step();
        reset = 0;
        check("reset_free", s_free, 32);

        // Dispatch fill and the 33rd request
        for (int k = 0; k < 32; k++) begin
            idle_in(); disp_req = 1; disp_dest = 1; step();
            check("fill_ack", s_ack, 1);
            check("fill_free", s_free, 32 - k);
        end
        step();
        check("fill_33_ack", s_ack, 0);
        check("fill_33_free", s_free, 0);

        // No same-cycle bypass from retire to dispatch
        ret_req = 1; step();
        check("nobyp_ack", s_ack, 0);
        ret_req = 0; step();
        check("nobyp_free", s_free, 1);
        check("nobyp_ack2", s_ack, 1);

        // Rollback to a checkpoint taken at head 5 with a destination
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle_in(); disp_req = 1; disp_dest = 1; step();
        end
        disp_br = 1; step();
        check("rb_tag", s_tag, 0);
        disp_br = 0;
        for (int k = 0; k < 3; k++) step();
        idle_in(); br_mispredict = 1; br_tag = 0; step();
        check("rb_mis_ack", s_ack, 0);
        idle_in(); step();
        check("rb_en", s_rb_en, 1);
        check("rb_idx6", s_rb_idx, 6);
        step();
        check("rb_free", s_free, 26);
        check("rb_en_off", s_rb_en, 0);

        // Checkpoint stack full, then freed by a resolve of tag 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle_in(); disp_req = 1; disp_br = 1; step();
            check("full_tag", s_tag, k);
        end
        step();
        check("full_flag", s_full, 1);
        check("full_stall", s_ack, 0);
        br_resolve = 1; br_tag = 0; step();
        check("full_res_ack", s_ack, 0);
        br_resolve = 0; step();
        check("full_reuse_ack", s_ack, 1);
        check("full_reuse_tag", s_tag, 0);

        // Nested mispredict squashes tags 1 and 2, keeps tag 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle_in(); disp_req = 1; disp_br = 1; step();
        end
        idle_in(); br_mispredict = 1; br_tag = 1; step();
        idle_in(); step();
        for (int k = 1; k < 4; k++) begin
            idle_in(); disp_req = 1; disp_br = 1; step();
            check("nest_tag", s_tag, k);
        end
        step();
        check("nest_full", s_full, 1);

        // Reset asserted during the ROLLBACK cycle
        do_reset();
        idle_in(); disp_req = 1; disp_br = 1; disp_dest = 1; step();
        idle_in(); disp_req = 1; disp_dest = 1; step();
        idle_in(); br_mispredict = 1; br_tag = 0; step();
        idle_in(); reset = 1; step();
        check("rstrb_en_before", s_rb_en, 1);
        idle_in(); disp_req = 1; step();
        check("rstrb_en", s_rb_en, 0);
        check("rstrb_free", s_free, 32);
        check("rstrb_full", s_full, 0);
        check("rstrb_idle_ack", s_ack, 1);

        // Randomized traffic
        idle_in();
        for (int n = 0; n < 4000; n++) begin
            idle_in();
            reset         = ($urandom_range(0, 299) == 0);
            disp_req      = ($urandom_range(0, 9) < 7);
            disp_dest     = ($urandom_range(0, 9) < 7);
            disp_br       = ($urandom_range(0, 3) == 0);
            ret_req       = (m_tail - low_ptr() < 32) && ($urandom_range(0, 1) == 1);
            br_resolve    = ($urandom_range(0, 6) == 0);
            br_mispredict = ($urandom_range(0, 19) == 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                br_tag = 2'(q[$urandom_range(0, q.size() - 1)].tag);
            else
                br_tag = 2'($urandom_range(0, 3));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fl_ctrl.md
# fl_ctrl

Free-list controller for the R10000-style rename stage. It sits between dispatch, retire and the branch unit on one side and the physical-register free list (FL) on the other, and generates the FL's `dispatch_en`, `retire_en`, `rollback_en` and `FL_rollback_idx`. It mirrors the FL head and tail pointers to track the free count and stall dispatch. It also keeps a circular stack of per-branch head checkpoints, so a mispredict restores the FL in one sequenced rollback cycle.

## Interface
- `NUM_FL`, 32, free-list entries (power of 2)
- `NUM_BR`, 4, branch checkpoints (power of 2)
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `disp_req`  in  1  dispatch slot holds an instruction
- `disp_dest`  in  1  instruction needs a physical register
- `disp_br`  in  1  instruction is a branch and needs a checkpoint
- `disp_ack`  out  1  dispatch accepted this cycle (combinational)
- `disp_br_tag`  out  log2(NUM_BR)  checkpoint tag for an accepted branch
- `ret_req`  in  1  retiring instruction frees a T_old
- `br_resolve`  in  1  branch resolved correctly
- `br_mispredict`  in  1  branch mispredicted
- `br_tag`  in  log2(NUM_BR)  tag of the resolving branch
- `dispatch_en`  out  1  to FL: allocate head
- `retire_en`  out  1  to FL: push T_old at tail
- `rollback_en`  out  1  to FL: restore head
- `FL_rollback_idx`  out  log2(NUM_FL)  restored head index
- `free_cnt`  out  log2(NUM_FL)+1  registered number of free entries
- `br_full`  out  1  all checkpoints in use

## Operation
- Pointers:
  - `head_x` and `tail_x` are log2(NUM_FL)+1 bits wide (index plus wrap bit).
  - `free_cnt = tail_x - head_x`, computed modulo 2^(log2(NUM_FL)+1).
  - Reset values: `head_x`=0, `tail_x`=NUM_FL, so `free_cnt`=NUM_FL.
- `disp_ack = disp_req & state==IDLE & !br_mispredict & !(disp_dest & free_cnt==0) & !(disp_br & br_full)`.
- `dispatch_en = disp_ack & disp_dest`.
  - On `dispatch_en`, `head_x` increments and the index wraps at NUM_FL.
- `retire_en = ret_req`.
  - Retire is never stalled, including in ROLLBACK.
  - On `retire_en`, `tail_x` increments.
  - Retire beyond NUM_FL free entries is illegal; no check is made.
- Checkpoint stack:
  - Storage: `ck_head_x[NUM_BR]`, `ck_valid[NUM_BR]`, and pointers `ck_old` and `ck_new`.
  - Accepted branch: entry `ck_new` gets `head_x + disp_dest`, so a link-register destination survives rollback.
  - In the same cycle, `disp_br_tag = ck_new`, `ck_valid` is set, and `ck_new` increments.
- `br_full` is true when `ck_valid[ck_new]` is set.
- `br_resolve` with a valid tag clears `ck_valid[br_tag]`.
  - `ck_old` then advances past the cleared entries at the oldest end, one entry per cycle.
- `br_mispredict` with a valid tag t:
  - Clears `ck_valid` for t and every younger entry, walking from t to `ck_new-1` with wrap.
  - Sets `ck_new = t`.
  - Latches `rb_idx = ck_head_x[t]`.
  - Enters ROLLBACK.
- A mispredict with an invalid tag is ignored.
- FSM:
  - IDLE: go to ROLLBACK on a valid mispredict.
  - ROLLBACK: `rollback_en`=1 and `FL_rollback_idx = rb_idx[low bits]`; `head_x <= rb_idx`; go to IDLE.
  - A valid mispredict during ROLLBACK (older branch) reloads `rb_idx` and stays in ROLLBACK one more cycle.
- Same-cycle events:
  - `br_resolve` and `br_mispredict` on different tags are both applied.
  - On the same tag, mispredict wins.
  - Retire concurrent with dispatch or rollback: both pointer updates apply, so the tail is never lost.
- Reset (any state, including mid-rollback):
  - Pointers return to their reset values; all checkpoints become invalid; state goes to IDLE.
  - All registered outputs go to 0, except `free_cnt`=NUM_FL.

## Timing
- `disp_ack`, `dispatch_en`, `retire_en`, `disp_br_tag` and `br_full` are combinational in the current cycle.
- `free_cnt` is registered:
  - It reflects dispatch and retire one cycle later.
  - No same-cycle bypass: a retire does not enable a dispatch when `free_cnt`=0 in that cycle.
- Mispredict sampled in cycle N:
  - `disp_ack`=0 in N.
  - Cycle N+1: `rollback_en`=1, `disp_ack`=0.
  - Cycle N+2: IDLE, and `free_cnt` reflects the restored head plus all retires through N+1.
- Checkpoint tags are reusable the cycle after their valid bit clears.

## Test plan
- Dispatch fill:
  - Stimulus: reset, then 32 back-to-back `disp_req`+`disp_dest`.
  - Required: 32 acks with head indices 0..31 and `free_cnt` reaching 0; the 33rd request gets `disp_ack`=0.
- No bypass:
  - Stimulus: at `free_cnt`=0, `ret_req` and `disp_req`+`disp_dest` in the same cycle.
  - Required: dispatch stalled that cycle; next cycle `free_cnt`=1 and dispatch acked.
- Rollback:
  - Stimulus: with `head_x`=5, dispatch a branch with dest; then 3 more dest instructions; then mispredict tag 0.
  - Required: tag=0, checkpoint=6; one cycle later `rollback_en`=1 with `FL_rollback_idx`=6; `free_cnt` restored to `tail_x`-6.
- Checkpoint full:
  - Stimulus: 4 branches outstanding, then a 5th branch; then `br_resolve` tag 0.
  - Required: `br_full`=1 and the 5th branch stalls; after the resolve, `ck_old` advances to 1 and the 5th branch is acked with tag 0.
- Nested mispredict:
  - Stimulus: tags 0,1,2 outstanding; mispredict tag 1.
  - Required: tags 1 and 2 invalidated, tag 0 valid; the next branch receives tag 1.
- Reset mid-rollback:
  - Stimulus: assert `reset` in the ROLLBACK cycle.
  - Required: next cycle `rollback_en`=0, `free_cnt`=32, `br_full`=0, state IDLE.
